// File: rtl/bram_dual_port_be.sv
// True dual-port block RAM with byte-lane write enables, selectable read-during-write
// behaviour, 1- or 2-stage read latency and a registered same-address collision flag.
module bram_dual_port_be #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            din_a,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             valid_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             valid_b,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  en_v    [2];
  logic [NB-1:0]         we_v    [2];
  logic [ADDR_WIDTH-1:0] addr_v  [2];
  logic [DATA_WIDTH-1:0] din_v   [2];
  logic [DATA_WIDTH-1:0] dout_v  [2];
  logic                  valid_v [2];

  assign en_v[0]   = en_a;
  assign en_v[1]   = en_b;
  assign we_v[0]   = we_a;
  assign we_v[1]   = we_b;
  assign addr_v[0] = addr_a;
  assign addr_v[1] = addr_b;
  assign din_v[0]  = din_a;
  assign din_v[1]  = din_b;

  assign dout_a  = dout_v[0];
  assign valid_a = valid_v[0];
  assign dout_b  = dout_v[1];
  assign valid_b = valid_v[1];

  // Port B lanes are written first so that port A's assignment wins on shared lanes.
  always_ff @(posedge clk) begin : write_ports
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (en_b && we_b[i])
          mem_q[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (en_a && we_a[i])
          mem_q[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic collision_d, collision_q;

  assign collision_d = en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));

  always_ff @(posedge clk) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= collision_d;
  end

  assign collision = collision_q;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    // Reads always see pre-edge contents; write-first only overlays this port's own lanes.
    always_comb begin
      rd_d = mem_q[addr_v[p]];
      if (RDW_MODE == 1) begin
        for (int i = 0; i < NB; i++) begin
          if (we_v[p][i])
            rd_d[i*BYTE_WIDTH +: BYTE_WIDTH] = din_v[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= en_v[p];
        if (en_v[p]) s1_data_q <= rd_d;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) s2_data_q <= s1_data_q;
        end
      end

      assign dout_v[p]  = s2_data_q;
      assign valid_v[p] = s2_valid_q;
    end else begin : g_lat1
      assign dout_v[p]  = s1_data_q;
      assign valid_v[p] = s1_valid_q;
    end
  end

endmodule

// File: tb/tb_bram_dual_port_be.sv
// Drives two RAM instances (latency 1 / read-first and latency 2 / write-first) with shared
// stimulus and compares both against a word-array reference model every cycle.
module tb_bram_dual_port_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        valid_a0, valid_b0, valid_a1, valid_b1;
  logic        coll0, coll1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_dual_port_be #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                      .READ_LATENCY(1), .RDW_MODE(0)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .valid_a(valid_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .valid_b(valid_b0),
    .collision(coll0));

  bram_dual_port_be #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                      .READ_LATENCY(2), .RDW_MODE(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .valid_a(valid_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .valid_b(valid_b1),
    .collision(coll1));

  // Reference model: memory words, per-instance expected outputs, one-deep delay for latency 2.
  logic [31:0] mMem [1024];
  logic [31:0] eDout  [2][2];
  logic        eValid [2][2];
  logic [31:0] pendD  [2];
  logic        pendV  [2];
  logic        eColl;
  logic        chkData;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ea, input logic [3:0] wa,
                               input logic [9:0] aa, input logic [31:0] da,
                               input logic eb, input logic [3:0] wb,
                               input logic [9:0] ab, input logic [31:0] db);
    logic        e [2];
    logic [3:0]  w [2];
    logic [9:0]  a [2];
    logic [31:0] d [2];
    logic [31:0] readFirst [2];
    logic [31:0] writeFirst [2];
    rst_n = r;
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    e[0] = ea; w[0] = wa; a[0] = aa; d[0] = da;
    e[1] = eb; w[1] = wb; a[1] = ab; d[1] = db;
    if (!r) begin
      for (int p = 0; p < 2; p++) begin
        eDout[0][p] = '0; eValid[0][p] = 1'b0;
        eDout[1][p] = '0; eValid[1][p] = 1'b0;
        pendV[p] = 1'b0;
      end
      eColl = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        readFirst[p]  = mMem[a[p]];
        writeFirst[p] = mMem[a[p]];
        for (int i = 0; i < 4; i++)
          if (w[p][i]) writeFirst[p][8*i +: 8] = d[p][8*i +: 8];
      end
      for (int i = 0; i < 4; i++) begin
        if (e[1] && w[1][i]) mMem[a[1]][8*i +: 8] = d[1][8*i +: 8];
        if (e[0] && w[0][i]) mMem[a[0]][8*i +: 8] = d[0][8*i +: 8];
      end
      for (int p = 0; p < 2; p++) begin
        eValid[0][p] = e[p];
        if (e[p]) eDout[0][p] = readFirst[p];
        eValid[1][p] = pendV[p];
        if (pendV[p]) eDout[1][p] = pendD[p];
        pendV[p] = e[p];
        if (e[p]) pendD[p] = writeFirst[p];
      end
      eColl = e[0] && e[1] && (a[0] == a[1]) && ((|w[0]) || (|w[1]));
    end
    @(posedge clk);
    #1;
    checkOutput("l1_valid_a", {31'b0, valid_a0}, {31'b0, eValid[0][0]});
    checkOutput("l1_valid_b", {31'b0, valid_b0}, {31'b0, eValid[0][1]});
    checkOutput("l2_valid_a", {31'b0, valid_a1}, {31'b0, eValid[1][0]});
    checkOutput("l2_valid_b", {31'b0, valid_b1}, {31'b0, eValid[1][1]});
    checkOutput("l1_collision", {31'b0, coll0}, {31'b0, eColl});
    checkOutput("l2_collision", {31'b0, coll1}, {31'b0, eColl});
    if (chkData) begin
      checkOutput("l1_dout_a", dout_a0, eDout[0][0]);
      checkOutput("l1_dout_b", dout_b0, eDout[0][1]);
      checkOutput("l2_dout_a", dout_a1, eDout[1][0]);
      checkOutput("l2_dout_b", dout_b1, eDout[1][1]);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
  endtask

  initial begin
    chkData = 1'b0;
    for (int i = 0; i < 1024; i++) mMem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      eDout[0][p] = '0; eDout[1][p] = '0;
      eValid[0][p] = 1'b0; eValid[1][p] = 1'b0;
      pendD[p] = '0; pendV[p] = 1'b0;
    end
    eColl = 1'b0;

    $display("[TB] start");
    applyStimulus(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);

    // Zero the whole array so that later reads have defined contents.
    for (int k = 0; k < 512; k++)
      applyStimulus(1'b1, 1'b1, 4'hF, 10'(2*k), 32'h0, 1'b1, 4'hF, 10'(2*k+1), 32'h0);

    // Reset with an active write request must neither write nor produce outputs.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 4'hF, 10'd5, 32'hDEAD_BEEF, 1'b0, 4'h0, 10'd0, 32'h0);
      chkData = 1'b1;
      checkOutput("rst_dout_a", dout_a0, 32'h0);
      checkOutput("rst_dout_a_l2", dout_a1, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    total++;
    assert (dout_a0 !== 32'hDEAD_BEEF) else begin
      bad++;
      $error("[TB] FAIL post_rst_read observed=%h expected=not deadbeef", dout_a0);
    end

    // Byte-lane writes.
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd7, 32'h1122_3344, 1'b0, 4'h0, 10'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'b0101, 10'd7, 32'hAABB_CCDD, 1'b0, 4'h0, 10'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    checkOutput("byte_en_read", dout_a0, 32'h11BB_33DD);

    // Read-during-write on port A at a zeroed address.
    applyStimulus(1'b1, 1'b1, 4'hF, 10'd3, 32'h5555_5555, 1'b0, 4'h0, 10'd0, 32'h0);
    checkOutput("rdw_read_first", dout_a0, 32'h0);
    idle();
    checkOutput("rdw_write_first", dout_a1, 32'h5555_5555);

    // Same-address collision with overlapping lanes.
    applyStimulus(1'b1, 1'b1, 4'b0011, 10'd9, 32'hAAAA_AAAA, 1'b1, 4'b0110, 10'd9, 32'hBBBB_BBBB);
    checkOutput("coll_pulse", {31'b0, coll0}, 32'h1);
    checkOutput("coll_wf_a", dout_a0, 32'h0);
    idle();
    checkOutput("coll_clear", {31'b0, coll0}, 32'h0);
    checkOutput("coll_wf_a_l2", dout_a1, 32'h0000_AAAA);
    checkOutput("coll_wf_b_l2", dout_b1, 32'h00BB_BB00);
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
    checkOutput("coll_merge", dout_b0, 32'h00BB_AAAA);

    // Back-to-back port B reads through the 2-stage pipeline.
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 1'b1, 4'hF, 10'(k), 32'h100 + 32'(k), 1'b0, 4'h0, 10'd0, 32'h0);
    idle();
    idle();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, (k < 4), 4'h0, 10'(k % 4), 32'h0);
      checkOutput("lat2_valid_b", {31'b0, valid_b1}, {31'b0, (k >= 1 && k <= 4)});
      if (k >= 1 && k <= 4) checkOutput("lat2_order_b", dout_b1, 32'h100 + 32'(k - 1));
    end

    // Reset lands while a latency-2 read is still in flight.
    idle();
    applyStimulus(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd1, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    checkOutput("flush_valid_b", {31'b0, valid_b1}, 32'h0);
    checkOutput("flush_dout_b", dout_b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    idle();
    checkOutput("flush_after_valid_b", {31'b0, valid_b1}, 32'h0);

    // Randomised traffic on a narrow address window to provoke collisions.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                    10'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                    10'($urandom_range(0, 15)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_dual_port_be.md
# bram_dual_port_be

True dual-port synchronous block RAM with per-byte write enables, selectable read-during-write behaviour, configurable read latency and deterministic same-address collision handling. It is the general-purpose on-chip memory for the M4 memory subsystem, sitting between two independent masters (e.g. a CPU-side port and a DMA-side port) on a single clock. Each port returns a valid strobe aligned with its read data. Collisions are flagged for debug counters.

## Interface
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, write-enable granularity; NB = DATA_WIDTH/BYTE_WIDTH lanes
- READ_LATENCY, 1, 1 = dout registered once; 2 = additional output register stage
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en_a  in  1  port A access request this cycle
- we_a  in  NB  port A byte write enables; ignored when en_a = 0
- addr_a  in  ADDR_WIDTH  port A word address
- din_a  in  DATA_WIDTH  port A write data
- dout_a  out  DATA_WIDTH  port A read data
- valid_a  out  1  dout_a carries the result of an access
- en_b, we_b, addr_b, din_b, dout_b, valid_b: identical for port B
- collision  out  1  one-cycle pulse: same-address conflict detected

## Operation
- Each edge with en_x = 1 performs one access on port x: a read of addr_x, plus a write of every byte lane i with we_x[i] = 1 (bits [i*BYTE_WIDTH +: BYTE_WIDTH]). Every enabled access, write or not, returns read data.
- Same-port read-during-write. RDW_MODE = 0 returns the pre-write word. RDW_MODE = 1 returns the old word with the port's own enabled lanes replaced by din_x.
- Cross-port reads always see pre-edge contents. The other port's same-cycle write is never forwarded.
- A collision occurs when en_a and en_b are both 1, addr_a == addr_b, and |we_a or |we_b.
- Both ports writing: per lane, port A wins where both enable the lane. Port B's data is stored in lanes only B enables. Lanes neither enables keep their old value.
- Read data on a colliding port follows the two rules above. Write-first never shows the other port's bytes.
- While rst_n = 0: no writes are performed, en is ignored, dout_x = 0, valid_x = 0, collision = 0. Memory contents are not cleared.
- When en_x = 0, dout_x holds its last value and valid_x = 0.

## Timing
- Access is sampled on edge N. dout_x and valid_x are updated after edge N+READ_LATENCY-1: visible in cycle N+1 for latency 1, cycle N+2 for latency 2. valid_x is high for exactly one cycle per access.
- Back-to-back accesses are fully pipelined: one access per port per cycle, with no bubbles at either latency.
- A written word is readable by either port from the access sampled on edge N+1 onward.
- collision is registered and asserts in cycle N+1 for an edge-N conflict, independent of READ_LATENCY.
- Reset mid-operation: in-flight pipeline stages are flushed. No valid_x fires for accesses sampled before or during reset. The first valid after reset release comes from the first access sampled with rst_n = 1.
- Address wrap: none. Addresses are exact and the full range 0..2**ADDR_WIDTH-1 is legal.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with en_a = 1, we_a = 4'hF, addr_a = 5, din_a = 32'hDEAD_BEEF -> outputs stay 0. After release, a read of addr 5 does not return 32'hDEAD_BEEF.
- Byte enables: write 32'h1122_3344 with we = 4'hF, then 32'hAABB_CCDD with we = 4'b0101 at addr 7 -> read returns 32'h11BB_33DD.
- RDW modes: addr 3 holds 32'h0, port A writes 32'h5555_5555 with we = 4'hF and reads the same cycle. RDW_MODE = 0 -> dout_a = 0. RDW_MODE = 1 -> dout_a = 32'h5555_5555.
- Collision: both ports write addr 9 with A = 32'hAAAA_AAAA, we = 4'b0011 and B = 32'hBBBB_BBBB, we = 4'b0110. Then:
  - collision pulses for one cycle in cycle N+1.
  - A later read of addr 9 returns 32'h00BB_AAAA, given prior contents 0.
- Latency: READ_LATENCY = 2, reads on port B on 4 consecutive cycles at addrs 0..3 -> valid_b is high for 4 consecutive cycles starting 2 cycles later, with data in order.
- Mid-flight reset: READ_LATENCY = 2, issue a read, then assert rst_n = 0 on the next edge -> no valid_b pulse, and dout_b = 0.
